button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
- Front-end stage for the clock/alarm/stopwatch controller.
- Takes the four raw, asynchronous push-button inputs (mode, set, op1, op2) and produces synchronized, debounced levels.
- Also produces single-cycle press/release pulses, plus optional auto-repeat pulses while a button is held.
- The controller consumes only these clean pulses; it never sees raw button edges.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive cycles a synchronized input must differ from the stable level before the stable level flips (10 ms at 50 MHz); legal range 2 to 2^CNT_W-1.
- REPEAT_DELAY, 25000000, cycles from a press pulse to the first repeat pulse (0.5 s).
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses (0.1 s); must be at least 1.
- CNT_W, 25, width of the per-channel debounce and repeat counters.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  reset, asynchronous, active-high.
- btn_raw  input  4  raw buttons; bit0 = mode, bit1 = set, bit2 = op1, bit3 = op2; active-high, asynchronous to clk.
- btn_level  output  4  debounced stable level per channel.
- btn_press  output  4  one-cycle pulse on each stable 0->1 transition.
- btn_release  output  4  one-cycle pulse on each stable 1->0 transition.
- btn_repeat  output  4  one-cycle auto-repeat pulses while held; constant 0 when the feature is compiled out.

Behaviour:
- Reset: all outputs 0; synchronizer flops, stable levels, and debounce/repeat counters cleared.
- The four channels are fully independent and identical. Any combination of channels may pulse in the same cycle; there is no priority or masking.
- Synchronizer: two flops per channel, giving sync2.
- Per-channel state machine:
  - STABLE_LO: exit to CHK_HI when sync2 = 1.
  - CHK_HI: counter increments each cycle while sync2 = 1. If sync2 = 0, clear the counter and return to STABLE_LO. When the counter reaches DEBOUNCE_CYCLES, go to STABLE_HI, set btn_level = 1, pulse btn_press.
  - STABLE_HI: exit to CHK_LO when sync2 = 0.
  - CHK_LO: mirror of CHK_HI. On completion, go to STABLE_LO, set btn_level = 0, pulse btn_release.
- The counter is cleared on every state change.
- Latency: let t0 be the first rising edge sampling btn_raw = 1.
  - btn_level and btn_press update at edge t0 + DEBOUNCE_CYCLES + 2.
  - btn_press is high for exactly one cycle.
  - Release latency is identical.
- Glitch rejection: a raw pulse or bounce shorter than DEBOUNCE_CYCLES consecutive sampled cycles never changes btn_level and produces no pulse. A bounce during CHK restarts the count from 0.
- btn_press and btn_release are never both high on the same channel in the same cycle.
- Counter saturation: the counter never exceeds DEBOUNCE_CYCLES; there is no wrap.
- Reset mid-operation: counts in progress are lost and stable levels drop to 0 immediately.
  - No release pulse is generated by reset.
  - A button still held after reset deasserts produces a normal press pulse after the full latency.

Optional Feature:
Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - Each channel has a repeat counter that clears on the btn_press cycle and counts while in STABLE_HI or CHK_LO.
  - The first btn_repeat pulse occurs REPEAT_DELAY cycles after the btn_press pulse; subsequent pulses occur every REPEAT_PERIOD cycles.
  - Repeat stops, with the counter cleared, on the cycle btn_level falls.
  - A repeat pulse is never coincident with btn_press; it may coincide with nothing else on that channel.
- Undefined: btn_repeat is tied to 4'b0000 and no repeat counters are synthesized.

Test Plan:
All scenarios use DEBOUNCE_CYCLES = 4, REPEAT_DELAY = 10, REPEAT_PERIOD = 3.
- Clean press: btn_raw[0] rises and is held -> btn_press = 4'b0001 for one cycle at edge t0+6; btn_level[0] = 1 from then on; no other bits change.
- Bounce: btn_raw[1] toggles 1,1,1,0,1,1,1,1 (one value per cycle) -> no pulse during the first run; btn_press[1] fires 6 edges after the final rising sample. Exactly one press pulse.
- Glitch: btn_raw[2] high for 3 cycles then low -> btn_level, btn_press, and btn_release stay 0 throughout.
- Simultaneous: btn_raw = 4'b1001 in the same cycle -> btn_press = 4'b1001 in a single cycle. Later release of both -> btn_release = 4'b1001 in one cycle, 6 edges after the release sample.
- Reset mid-hold: btn_level[3] = 1, then reset is pulsed for 2 cycles while btn_raw[3] stays 1 -> outputs go to 0 asynchronously with no release pulse; btn_press[3] fires 6 edges after the first post-reset edge.
- Auto-repeat (BTN_AUTOREPEAT_EN defined): hold btn_raw[1] -> btn_repeat[1] pulses at press+10, +13, +16, …; pulses stop once btn_level[1] falls. With the macro undefined, btn_repeat stays 0.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes and debounces the four push buttons
// (bit0 mode, bit1 set, bit2 op1, bit3 op2). It produces a stable level
// and one-cycle press/release pulses for each button.
// Optional macro BTN_AUTOREPEAT_EN adds per-channel auto-repeat pulses while
// a button is held. Without it, btn_repeat is tied low.
//
// Per-channel states:
//   state     | meaning
//   STABLE_LO | debounced level is 0, waiting for sync input to go high
//   CHK_HI    | input high, counting consecutive high cycles
//   STABLE_HI | debounced level is 1, waiting for sync input to go low
//   CHK_LO    | input low, counting consecutive low cycles
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000,
    parameter int unsigned CNT_W           = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_raw,
    output logic [3:0] btn_level,
    output logic [3:0] btn_press,
    output logic [3:0] btn_release,
    output logic [3:0] btn_repeat
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } state_e;

    // The count compares against DEBOUNCE_CYCLES-1 because the flip itself
    // happens on the edge that would bring the count to DEBOUNCE_CYCLES.
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
    // The repeat counter is a down-counter. A pulse fires on the cycle after
    // it reaches zero, so the reload values are the interval minus one.
    localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(REPEAT_PERIOD - 1);
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;

    // Two-flop synchronizer next-state for all four raw inputs.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
    end

    // Synchronizer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_ch
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             level_q, level_d;
        logic             press_q, press_d;
        logic             release_q, release_d;

        // Debounce FSM next-state; pulses come from the transition itself.
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            case (state_q)
                STABLE_LO: if (sync2_q[g]) state_d = CHK_HI;
                CHK_HI: begin
                    if (!sync2_q[g]) begin
                        state_d = STABLE_LO;
                    end else if (cnt_q >= DEB_LAST) begin
                        state_d = STABLE_HI;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STABLE_HI: if (!sync2_q[g]) state_d = CHK_LO;
                CHK_LO: begin
                    if (sync2_q[g]) begin
                        state_d = STABLE_HI;
                    end else if (cnt_q >= DEB_LAST) begin
                        state_d   = STABLE_LO;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = STABLE_LO;
            endcase
            if (state_d != state_q) cnt_d = '0;
        end

        // Debounce FSM state, counter and registered outputs.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q   <= STABLE_LO;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        assign btn_level[g]   = level_q;
        assign btn_press[g]   = press_q;
        assign btn_release[g] = release_q;

`ifdef BTN_AUTOREPEAT_EN
        logic [CNT_W-1:0] rpt_q, rpt_d;
        logic             repeat_q, repeat_d;

        // Repeat timer. It is armed on the press edge and runs while the
        // level is high. It is dropped on the release edge, so it never
        // fires alongside press or release.
        always_comb begin
            rpt_d    = rpt_q;
            repeat_d = 1'b0;
            if (press_d) begin
                rpt_d = RPT_FIRST;
            end else if (release_d) begin
                rpt_d = '0;
            end else if (state_q == STABLE_HI || state_q == CHK_LO) begin
                if (rpt_q == '0) begin
                    repeat_d = 1'b1;
                    rpt_d    = RPT_NEXT;
                end else begin
                    rpt_d = rpt_q - 1'b1;
                end
            end
        end

        // Repeat timer and pulse registers.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rpt_q    <= '0;
                repeat_q <= 1'b0;
            end else begin
                rpt_q    <= rpt_d;
                repeat_q <= repeat_d;
            end
        end

        assign btn_repeat[g] = repeat_q;
`else
        assign btn_repeat[g] = 1'b0;
`endif
    end

endmodule
